mult_add_2_sched: RTL and testbench

//  Round-robin scheduler sharing one mult_add_2 datapath (a0*b0 + a1*b1) among NUM_REQ requesters.

---
 rtl/mult_add_2_sched.sv | 192 +++++++++++++++++++
 tb/tb_mult_add_2_sched.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_add_2_sched.sv
// Round-robin scheduler sharing one mult_add_2 datapath among requesters.
// Tracks in-flight ops by ID and supports locked FIR bursts.
module mult_add_2_sched #(
  parameter int NUM_REQ        = 3,
  parameter int ID_W           = 2,
  parameter int INPUT_DATA_A_W = 8,
  parameter int INPUT_DATA_B_W = 8,
  parameter int OUTPUT_DATA_W  = 8,
  parameter int DP_LATENCY     = 3,
  parameter int BURST_MAX      = 8
) (
  input  logic                                CLK_i,
  input  logic                                RST_i,
  input  logic [NUM_REQ-1:0]                  req_i,
  input  logic [NUM_REQ-1:0]                  fir_i,
  input  logic [2*NUM_REQ-1:0]                calcop_i,
  input  logic [INPUT_DATA_A_W*NUM_REQ-1:0]   a0_i,
  input  logic [INPUT_DATA_A_W*NUM_REQ-1:0]   a1_i,
  input  logic [INPUT_DATA_B_W*NUM_REQ-1:0]   b0_i,
  input  logic [INPUT_DATA_B_W*NUM_REQ-1:0]   b1_i,
  output logic [NUM_REQ-1:0]                  gnt_o,
  output logic [1:0]                          dp_inopcode_o,
  output logic [1:0]                          dp_calcopcode_o,
  output logic [INPUT_DATA_A_W-1:0]           dp_a0_o,
  output logic [INPUT_DATA_A_W-1:0]           dp_a1_o,
  output logic [INPUT_DATA_B_W-1:0]           dp_b0_o,
  output logic [INPUT_DATA_B_W-1:0]           dp_b1_o,
  input  logic [OUTPUT_DATA_W-1:0]            dp_result_i,
  output logic                                res_valid_o,
  output logic [ID_W-1:0]                     res_id_o,
  output logic [OUTPUT_DATA_W-1:0]            res_data_o
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LOCK = 1'b1;

  logic [0:0]          state;
  logic [ID_W-1:0]     ptr;
  logic [ID_W-1:0]     owner;
  logic [CNT_W-1:0]    cnt;

  logic [NUM_REQ-1:0]  own_oh;
  logic [NUM_REQ-1:0]  hi_g;
  logic [NUM_REQ-1:0]  lo_g;
  logic [NUM_REQ-1:0]  rr_gnt;
  logic [NUM_REQ-1:0]  gnt;
  logic                hi_f;
  logic                lo_f;
  logic                in_lock;
  logic                lock_hold;
  logic                gnt_any;
  logic                gnt_fir;
  logic [ID_W-1:0]     start;
  logic [ID_W-1:0]     gnt_id;

  logic [1:0]                 sel_cop;
  logic [INPUT_DATA_A_W-1:0]  sel_a0;
  logic [INPUT_DATA_A_W-1:0]  sel_a1;
  logic [INPUT_DATA_B_W-1:0]  sel_b0;
  logic [INPUT_DATA_B_W-1:0]  sel_b1;

  logic [DP_LATENCY:0] vpipe;
  logic [ID_W-1:0]     idpipe [DP_LATENCY+1];

  function automatic logic [ID_W-1:0] next_id(
    input logic [ID_W-1:0] id
  );
    return (id == LAST_ID) ? '0 : id + 1'b1;
  endfunction

  always_comb begin
    own_oh = '0;
    for (int k = 0; k < NUM_REQ; k++)
      own_oh[k] = (ID_W'(k) == owner);
  end

  assign in_lock = (state == S_LOCK);
  assign lock_hold = in_lock
                   && (|(req_i & fir_i & own_oh))
                   && (cnt < CNT_MAX);
  // leaving a lock makes the owner lowest priority
  assign start = in_lock ? next_id(owner) : ptr;

  always_comb begin
    hi_g = '0;
    lo_g = '0;
    hi_f = 1'b0;
    lo_f = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_i[k] && (k >= int'(start)) && !hi_f) begin
        hi_g[k] = 1'b1;
        hi_f    = 1'b1;
      end
      if (req_i[k] && !lo_f) begin
        lo_g[k] = 1'b1;
        lo_f    = 1'b1;
      end
    end
    rr_gnt = hi_f ? hi_g : lo_g;
  end

  assign gnt     = RST_i ? '0 : (lock_hold ? own_oh : rr_gnt);
  assign gnt_o   = gnt;
  assign gnt_any = |gnt;
  assign gnt_fir = |(gnt & fir_i);

  always_comb begin
    gnt_id  = '0;
    sel_cop = '0;
    sel_a0  = '0;
    sel_a1  = '0;
    sel_b0  = '0;
    sel_b1  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        gnt_id  = ID_W'(k);
        sel_cop = calcop_i[2*k +: 2];
        sel_a0  = a0_i[k*INPUT_DATA_A_W +: INPUT_DATA_A_W];
        sel_a1  = a1_i[k*INPUT_DATA_A_W +: INPUT_DATA_A_W];
        sel_b0  = b0_i[k*INPUT_DATA_B_W +: INPUT_DATA_B_W];
        sel_b1  = b1_i[k*INPUT_DATA_B_W +: INPUT_DATA_B_W];
      end
    end
  end

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      state <= S_IDLE;
      ptr   <= '0;
      owner <= '0;
      cnt   <= '0;
    end else if (gnt_any && gnt_fir) begin
      state <= S_LOCK;
      owner <= gnt_id;
      cnt   <= lock_hold ? cnt + 1'b1 : CNT_W'(1);
    end else if (gnt_any) begin
      state <= S_IDLE;
      ptr   <= next_id(gnt_id);
      cnt   <= '0;
    end else begin
      if (in_lock)
        ptr <= next_id(owner);
      state <= S_IDLE;
      cnt   <= '0;
    end
  end

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      dp_inopcode_o   <= 2'b00;
      dp_calcopcode_o <= 2'b00;
      dp_a0_o         <= '0;
      dp_a1_o         <= '0;
      dp_b0_o         <= '0;
      dp_b1_o         <= '0;
    end else if (gnt_any) begin
      dp_inopcode_o   <= gnt_fir ? 2'b10 : 2'b01;
      dp_calcopcode_o <= sel_cop;
      dp_a0_o         <= sel_a0;
      dp_a1_o         <= sel_a1;
      dp_b0_o         <= sel_b0;
      dp_b1_o         <= sel_b1;
    end else begin
      dp_inopcode_o   <= 2'b00;
    end
  end

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      vpipe       <= '0;
      for (int i = 0; i <= DP_LATENCY; i++)
        idpipe[i] <= '0;
      res_valid_o <= 1'b0;
      res_id_o    <= '0;
      res_data_o  <= '0;
    end else begin
      vpipe     <= {vpipe[DP_LATENCY-1:0], gnt_any};
      idpipe[0] <= gnt_id;
      for (int i = 1; i <= DP_LATENCY; i++)
        idpipe[i] <= idpipe[i-1];
      res_valid_o <= vpipe[DP_LATENCY];
      if (vpipe[DP_LATENCY]) begin
        res_id_o   <= idpipe[DP_LATENCY];
        res_data_o <= dp_result_i;
      end
    end
  end

endmodule

// File: tb/tb_mult_add_2_sched.sv
// Directed bench for mult_add_2_sched with a datapath model
// and a result scoreboard.
module tb_mult_add_2_sched;

  localparam int NR  = 3;
  localparam int LAT = 3;

  logic          CLK_i = 1'b0;
  logic          RST_i = 1'b1;
  logic [NR-1:0] req_i;
  logic [NR-1:0] fir_i;
  logic [2*NR-1:0] calcop_i;
  logic [8*NR-1:0] a0_i, a1_i, b0_i, b1_i;
  logic [NR-1:0] gnt_o;
  logic [1:0]    dp_inopcode_o, dp_calcopcode_o;
  logic [7:0]    dp_a0_o, dp_a1_o, dp_b0_o, dp_b1_o;
  logic [7:0]    dp_result_i;
  logic          res_valid_o;
  logic [1:0]    res_id_o;
  logic [7:0]    res_data_o;

  mult_add_2_sched dut (
    .CLK_i(CLK_i), .RST_i(RST_i),
    .req_i(req_i), .fir_i(fir_i),
    .calcop_i(calcop_i),
    .a0_i(a0_i), .a1_i(a1_i),
    .b0_i(b0_i), .b1_i(b1_i),
    .gnt_o(gnt_o),
    .dp_inopcode_o(dp_inopcode_o),
    .dp_calcopcode_o(dp_calcopcode_o),
    .dp_a0_o(dp_a0_o), .dp_a1_o(dp_a1_o),
    .dp_b0_o(dp_b0_o), .dp_b1_o(dp_b1_o),
    .dp_result_i(dp_result_i),
    .res_valid_o(res_valid_o),
    .res_id_o(res_id_o),
    .res_data_o(res_data_o)
  );

  always #5 CLK_i = ~CLK_i;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic [1:0] prev_inop = 2'b00;

  logic [7:0] op_a0 [NR];
  logic [7:0] op_a1 [NR];
  logic [7:0] op_b0 [NR];
  logic [7:0] op_b1 [NR];
  logic [1:0] op_c  [NR];

  function automatic logic [7:0] model(
    input logic [1:0] c,
    input logic [7:0] x0, y0, x1, y1
  );
    logic [16:0] s;
    s = {9'd0, x0} * {9'd0, y0} + {9'd0, x1} * {9'd0, y1};
    case (c)
      2'b01:   return x0;
      2'b10:   return x1;
      default: return s[15:8];
    endcase
  endfunction

  // Datapath model: result DP_LATENCY cycles after the dp_* outputs.
  logic [7:0] dpp [LAT];
  always @(posedge CLK_i) begin
    dpp[0] <= model(dp_calcopcode_o, dp_a0_o, dp_b0_o,
                    dp_a1_o, dp_b1_o);
    for (int i = 1; i < LAT; i++)
      dpp[i] <= dpp[i-1];
  end
  assign dp_result_i = dpp[LAT-1];

  always @(posedge CLK_i) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, expv);
    end
  endtask

  task automatic set_op(input int k, input logic [1:0] c,
                        input logic [7:0] x0, y0, x1, y1);
    op_c[k]  = c;
    op_a0[k] = x0;
    op_b0[k] = y0;
    op_a1[k] = x1;
    op_b1[k] = y1;
    calcop_i[2*k +: 2] = c;
    a0_i[8*k +: 8] = x0;
    b0_i[8*k +: 8] = y0;
    a1_i[8*k +: 8] = x1;
    b1_i[8*k +: 8] = y1;
  endtask

  task automatic step(input logic [NR-1:0] eg, input bit push);
    exp_t e;
    int   id;
    @(negedge CLK_i);
    chk("gnt", gnt_o, eg);
    chk("inop", dp_inopcode_o, prev_inop);
    id = 0;
    for (int k = 0; k < NR; k++)
      if (eg[k]) id = k;
    if (eg == '0)          prev_inop = 2'b00;
    else if (fir_i[id])    prev_inop = 2'b10;
    else                   prev_inop = 2'b01;
    if (push && eg != '0) begin
      e.id   = 2'(id);
      e.data = model(op_c[id], op_a0[id], op_b0[id],
                     op_a1[id], op_b1[id]);
      e.due  = cyc + 2 + LAT;
      sb.push_back(e);
    end
    @(posedge CLK_i);
    #1;
  endtask

  // Result monitor: pops the scoreboard on each result strobe.
  always @(negedge CLK_i) begin
    exp_t e;
    if (!RST_i) begin
      if (res_valid_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", res_valid_o, 1'b0);
        end else begin
          e = sb.pop_front();
          chk("res_id", res_id_o, e.id);
          chk("res_data", res_data_o, e.data);
          chk("res_cycle", cyc, e.due);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        chk("missing_valid", res_valid_o, 1'b1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    req_i = '0;
    fir_i = '0;
    calcop_i = '0;
    a0_i = '0; a1_i = '0; b0_i = '0; b1_i = '0;
    for (int k = 0; k < NR; k++)
      set_op(k, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0);

    // reset with requests pending
    req_i = 3'b111;
    @(posedge CLK_i);
    #1;
    step(3'b000, 0);
    step(3'b000, 0);
    chk("rst_inop", dp_inopcode_o, 2'b00);
    chk("rst_a0", dp_a0_o, 8'd0);
    chk("rst_valid", res_valid_o, 1'b0);
    chk("rst_id", res_id_o, 2'd0);
    chk("rst_data", res_data_o, 8'd0);
    RST_i = 1'b0;

    // round-robin fairness
    set_op(0, 2'b00, 8'd100, 8'd50, 8'd3, 8'd7);
    set_op(1, 2'b00, 8'd200, 8'd200, 8'd10, 8'd10);
    set_op(2, 2'b00, 8'd255, 8'd128, 8'd1, 8'd1);
    req_i = 3'b111;
    step(3'b001, 1);
    step(3'b010, 1);
    step(3'b100, 1);
    step(3'b001, 1);
    step(3'b010, 1);
    step(3'b100, 1);
    req_i = 3'b000;
    repeat (6) step(3'b000, 0);

    // single op, then idle gap
    set_op(1, 2'b00, 8'd10, 8'd3, 8'd2, 8'd5);
    req_i = 3'b010;
    step(3'b010, 1);
    req_i = 3'b000;
    chk("single_a0", dp_a0_o, 8'd10);
    chk("single_b0", dp_b0_o, 8'd3);
    chk("single_a1", dp_a1_o, 8'd2);
    chk("single_b1", dp_b1_o, 8'd5);
    chk("single_cop", dp_calcopcode_o, 2'b00);
    for (int i = 0; i < 9; i++) begin
      step(3'b000, 0);
      chk("idle_inop", dp_inopcode_o, 2'b00);
      chk("idle_a0", dp_a0_o, 8'd10);
      if (i >= 4)
        chk("idle_valid", res_valid_o, 1'b0);
    end

    // reset with three ops in flight
    set_op(0, 2'b00, 8'd9, 8'd9, 8'd9, 8'd9);
    set_op(2, 2'b00, 8'd7, 8'd7, 8'd7, 8'd7);
    req_i = 3'b111;
    step(3'b100, 0);
    step(3'b001, 0);
    step(3'b010, 0);
    RST_i = 1'b1;
    sb.delete();
    step(3'b000, 0);
    RST_i = 1'b0;
    req_i = 3'b000;
    chk("rst2_inop", dp_inopcode_o, 2'b00);
    chk("rst2_cop", dp_calcopcode_o, 2'b00);
    chk("rst2_a0", dp_a0_o, 8'd0);
    chk("rst2_b1", dp_b1_o, 8'd0);
    chk("rst2_valid", res_valid_o, 1'b0);
    chk("rst2_id", res_id_o, 2'd0);
    chk("rst2_data", res_data_o, 8'd0);
    for (int i = 0; i < 6; i++) begin
      step(3'b000, 0);
      chk("rst2_quiet", res_valid_o, 1'b0);
    end

    // FIR burst lock with forced release
    set_op(0, 2'b00, 8'd60, 8'd70, 8'd80, 8'd90);
    set_op(1, 2'b00, 8'd33, 8'd44, 8'd55, 8'd66);
    fir_i = 3'b001;
    req_i = 3'b011;
    repeat (8) step(3'b001, 1);
    step(3'b010, 1);
    req_i = 3'b001;
    repeat (3) step(3'b001, 1);
    // owner drops fir: lock exits, owner lowest priority
    set_op(2, 2'b00, 8'd250, 8'd250, 8'd0, 8'd0);
    fir_i = 3'b000;
    req_i = 3'b101;
    step(3'b100, 1);
    req_i = 3'b001;
    step(3'b001, 1);
    req_i = 3'b000;

    // bypass ops
    set_op(2, 2'b01, 8'hAB, 8'h11, 8'h22, 8'h33);
    req_i = 3'b100;
    step(3'b100, 1);
    set_op(0, 2'b10, 8'h12, 8'h34, 8'h5C, 8'h78);
    req_i = 3'b001;
    step(3'b001, 1);
    req_i = 3'b000;
    repeat (10) step(3'b000, 0);
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
